iram_refill_ctrl: RTL and testbench

IRAM_REFILL_CTRL -- requirements
Module: iram_refill_ctrl

---
 rtl/iram_refill_ctrl_pkg.sv | 22 ++
 rtl/iram_refill_fifo.sv | 50 +++++
 rtl/iram_refill_ctrl.sv | 156 +++++++++++++++
 tb/tb_iram_refill_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iram_refill_ctrl_pkg.sv
// Shared types and defaults for the instruction-RAM refill controller.
// PC_SIZE / MEMORY_WORD fall back to local defaults when the codebase headers do not supply them.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif
`ifndef MEMORY_WORD
`define MEMORY_WORD 32
`endif

package iram_refill_ctrl_pkg;

  localparam int unsigned LINE_WORDS_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } refill_state_t;

endpackage

// File: rtl/iram_refill_fifo.sv
// Two-entry return buffer between backing-memory read data and the core.
module iram_refill_fifo #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [WORD_W-1:0] wdata,
    input  logic              pop,
    output logic [WORD_W-1:0] rdata,
    output logic [1:0]        count,
    output logic              empty
);

    logic [WORD_W-1:0] slots [2];
    logic              wr_ptr;
    logic              rd_ptr;

    assign rdata = slots[rd_ptr];
    assign empty = (count == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots[0] <= '0;
            slots[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= wdata;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iram_refill_ctrl.sv
// Instruction-RAM line refill controller: issues LINE_WORDS reads, delivers words one per pulse.
// Define IRAM_CRITICAL_WORD_FIRST_EN to start at the missed word and wrap within the line.
module iram_refill_ctrl
  import iram_refill_ctrl_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int unsigned ADDR_W     = `PC_SIZE,
  parameter int unsigned WORD_W     = `MEMORY_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] iram_address,
  output logic [WORD_W-1:0] imem_word,
  output logic              word_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              refill_busy
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = OFF_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(LINE_WORDS - 1);

  refill_state_t     state;
  refill_state_t     state_nx;

  logic [ADDR_W-1:0] line_base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  deliver_cnt;
  logic [1:0]        outstanding;
  logic [OFF_W-1:0]  issue_off;
`ifdef IRAM_CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0]  start_off;
`endif

  logic              active;
  logic              credit_ok;
  logic              grant;
  logic              rvalid_acc;
  logic              last_grant;
  logic              last_word;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [WORD_W-1:0] fifo_rdata;

`ifdef IRAM_CRITICAL_WORD_FIRST_EN
  assign issue_off = issue_cnt[OFF_W-1:0] + start_off;
`else
  assign issue_off = issue_cnt[OFF_W-1:0];
`endif
  assign mem_addr = line_base | ADDR_W'(issue_off);

  // Buffered words hold credits too, so in-flight plus buffered never exceeds the two FIFO slots.
  assign credit_ok   = ({1'b0, outstanding} + {1'b0, fifo_count}) < 3'd2;
  assign active      = ((state == ISSUE) || (state == DRAIN)) && i_miss;
  assign mem_req     = (state == ISSUE) && i_miss && credit_ok;
  assign grant       = mem_req && mem_gnt;
  // Returns with nothing in flight (e.g. stragglers after reset) are dropped.
  assign rvalid_acc  = mem_rvalid && (outstanding != 2'd0);
  assign fifo_push   = rvalid_acc && active;
  assign fifo_pop    = active && !fifo_empty && !word_ready;
  assign fifo_flush  = (state == IDLE) || (state == ABORT);
  assign last_grant  = grant && (issue_cnt == LAST_IDX);
  assign last_word   = word_ready && (deliver_cnt == LAST_IDX);
  assign refill_busy = (state != IDLE);

  iram_refill_fifo #(
    .WORD_W(WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (mem_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_miss) state_nx = ISSUE;
      end
      ISSUE: begin
        if (!i_miss)         state_nx = ABORT;
        else if (last_grant) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!i_miss)        state_nx = ABORT;
        else if (last_word) state_nx = DONE;
      end
      DONE: begin
        if (!i_miss) state_nx = IDLE;
      end
      ABORT: begin
        if (outstanding == 2'd0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_base   <= '0;
`ifdef IRAM_CRITICAL_WORD_FIRST_EN
      start_off   <= '0;
`endif
      issue_cnt   <= '0;
      deliver_cnt <= '0;
      outstanding <= '0;
      word_ready  <= 1'b0;
      imem_word   <= '0;
    end else begin
      if ((state == IDLE) && i_miss) begin
        line_base   <= iram_address & ~OFF_MASK;
`ifdef IRAM_CRITICAL_WORD_FIRST_EN
        start_off   <= iram_address[OFF_W-1:0];
`endif
        issue_cnt   <= '0;
        deliver_cnt <= '0;
      end else begin
        if (grant)      issue_cnt   <= issue_cnt + CNT_W'(1);
        if (word_ready) deliver_cnt <= deliver_cnt + CNT_W'(1);
      end

      case ({grant, rvalid_acc})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase

      word_ready <= fifo_pop;
      imem_word  <= fifo_pop ? fifo_rdata : '0;
    end
  end

endmodule

// File: tb/tb_iram_refill_ctrl.sv
// Directed bench for iram_refill_ctrl with a fixed-latency in-order memory model.
module tb_iram_refill_ctrl;

    logic        clk;
    logic        rst;
    logic        i_miss;
    logic [15:0] iram_address;
    logic [31:0] imem_word;
    logic        word_ready;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        refill_busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    iram_refill_ctrl #(
        .LINE_WORDS(16),
        .ADDR_W    (16),
        .WORD_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_miss      (i_miss),
        .iram_address(iram_address),
        .imem_word   (imem_word),
        .word_ready  (word_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .refill_busy (refill_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    function automatic logic [15:0] exp_addr(input logic [15:0] miss, input int k);
        logic [15:0] base;
        logic [3:0]  off;
        base = miss & 16'hFFF0;
`ifdef IRAM_CRITICAL_WORD_FIRST_EN
        off = 4'(int'(miss[3:0]) + k);
`else
        off = 4'(k);
`endif
        return base | {12'h000, off};
    endfunction

    // Memory model: read data returns (tap+1) cycles after the grant, in order; not reset.
    logic [7:0]  pv = '0;
    logic [15:0] pa [8];
    logic [2:0]  tap = 3'd1;

    always @(posedge clk) begin
        pv    <= {pv[6:0], mem_req & mem_gnt};
        pa[0] <= mem_addr;
        for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
    end
    assign mem_rvalid = pv[tap];
    assign mem_rdata  = data_of(pa[tap]);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refill(input logic [15:0] miss, input int stall_at, output logic [31:0] first_word);
        int gcnt, wcnt, cyc, last_w, bo, max_bo, stall_left;
        bit stalled, req_seen;
        logic [15:0] held;
        gcnt = 0; wcnt = 0; cyc = 0; last_w = -100; bo = 0; max_bo = 0;
        stall_left = 0; stalled = 0; req_seen = 0; held = '0;
        first_word = '0;
        mem_gnt = 1'b1;
        iram_address = miss;
        i_miss = 1'b1;
        while (wcnt < 16 && cyc < 600) begin
            @(negedge clk); #1;
            cyc++;
            if (stall_left == 0 && !stalled && stall_at >= 0 && gcnt == stall_at) begin
                stalled = 1;
                stall_left = 5;
            end
            mem_gnt = (stall_left == 0);
            if (stall_left > 0) begin
                if (req_seen) begin
                    check("stall_req_held", mem_req, 1'b1);
                    check("stall_addr_stable", mem_addr, held);
                end else if (mem_req) begin
                    req_seen = 1;
                    held = mem_addr;
                end
                stall_left--;
            end
            if (mem_req && mem_gnt) begin
                check($sformatf("addr_%0h_%0d", miss, gcnt), mem_addr, exp_addr(miss, gcnt));
                gcnt++;
                bo++;
            end
            if (mem_rvalid) bo--;
            if (bo > max_bo) max_bo = bo;
            if (word_ready) begin
                if (wcnt == 0) first_word = imem_word;
                check($sformatf("data_%0h_%0d", miss, wcnt), imem_word, data_of(exp_addr(miss, wcnt)));
                check("pulse_gap", 64'(cyc - last_w >= 2), 64'd1);
                last_w = cyc;
                wcnt++;
            end
        end
        check("words_delivered", wcnt, 16);
        check("grants_issued", gcnt, 16);
        check("max_outstanding_le2", 64'(max_bo <= 2), 64'd1);
        if (stall_at >= 0) check("stall_saw_req", req_seen, 1'b1);
        @(negedge clk); #1;
        check("done_busy", refill_busy, 1'b1);
        check("done_no_pulse", word_ready, 1'b0);
        i_miss = 1'b0;
        @(negedge clk); #1;
        check("idle_after_done", refill_busy, 1'b0);
    endtask

    initial begin
        logic [31:0] fw;
        int gcnt, wcnt, bo, cyc;
        bit bad_pulse, bad_req;

        rst = 1'b1; i_miss = 1'b0; iram_address = '0; mem_gnt = 1'b1;
        #12;
        check("rst_word_ready", word_ready, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_busy", refill_busy, 1'b0);
        check("rst_imem_word", imem_word, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;

        // Basic line, then an immediate back-to-back miss on another line.
        refill(16'h0023, -1, fw);
        refill(16'h0050, -1, fw);

        // Critical word first (when enabled) combined with a 5-cycle grant stall.
        refill(16'h002E, 6, fw);
`ifdef IRAM_CRITICAL_WORD_FIRST_EN
        check("cwf_first_word", fw, 32'h5A74002E);
`else
        check("cwf_first_word", fw, 32'h5A7A0020);
`endif

        // Abort after 5 words with two reads in flight (long memory latency).
        tap = 3'd5;
        gcnt = 0; wcnt = 0; bo = 0; cyc = 0;
        iram_address = 16'h0060;
        i_miss = 1'b1;
        while (cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
            if (wcnt >= 5 && bo == 2) break;
            if (mem_req && mem_gnt) begin gcnt++; bo++; end
            if (mem_rvalid) bo--;
            if (word_ready) begin
                check($sformatf("abort_data_%0d", wcnt), imem_word, data_of(exp_addr(16'h0060, wcnt)));
                wcnt++;
            end
        end
        check("abort_two_outstanding", bo, 2);
        i_miss = 1'b0;
        #1;
        check("abort_req_drop", mem_req, 1'b0);
        if (mem_rvalid) bo--;
        bad_pulse = 0; bad_req = 0; cyc = 0;
        while (cyc < 30) begin
            @(negedge clk); #1;
            cyc++;
            if (word_ready) bad_pulse = 1;
            if (mem_req) bad_req = 1;
            if (!refill_busy) break;
            if (mem_rvalid) bo--;
        end
        check("abort_no_pulse", bad_pulse, 1'b0);
        check("abort_no_req", bad_req, 1'b0);
        check("abort_idle_after_returns", bo, 0);
        check("abort_busy_low", refill_busy, 1'b0);
        tap = 3'd1;
        @(negedge clk); #1;
        refill(16'h0070, -1, fw);

        // Reset during DRAIN, then a fresh line at 0x40.
        gcnt = 0; cyc = 0;
        iram_address = 16'h0030;
        i_miss = 1'b1;
        while (gcnt < 16 && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
            if (mem_req && mem_gnt) gcnt++;
        end
        @(negedge clk); #1;
        check("pre_rst_busy", refill_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_word_ready", word_ready, 1'b0);
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_busy", refill_busy, 1'b0);
        check("midrst_imem_word", imem_word, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        i_miss = 1'b0;
        bad_pulse = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (word_ready || refill_busy) bad_pulse = 1;
        end
        check("post_rst_quiet", bad_pulse, 1'b0);
        refill(16'h0040, -1, fw);
        check("post_rst_first_word", fw, 32'h5A1A0040);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
